// File: rtl/lsu_pkg.sv
// Shared constants and types for the data memory load/store unit.
package lsu_pkg;

  // RV32I load/store funct3 width/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/data_mem_align.sv
// Combinational store lane alignment and access legality checks.
module data_mem_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic        illegal
);

  // Decode width, derive byte enables, replicate data, flag bad accesses
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    illegal   = 1'b0;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_H: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = off[0];
      end
      F3_W: begin
        be        = 4'b1111;
        misalign  = (off != 2'b00);
      end
      // Unsigned variants exist only for loads
      F3_BU: begin
        illegal   = we;
      end
      F3_HU: begin
        illegal   = we;
        misalign  = off[0];
      end
      default: begin
        illegal   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Handshaked data memory with load/store alignment and post-reset zero sweep.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned MemAw = $clog2(DEPTH);
  localparam dmem_state_e RstState = (INIT_ZERO != 0) ? INIT : RUN;

  logic [31:0] mem [DEPTH];

  dmem_state_e      state_q, state_d;
  logic [MemAw-1:0] clr_idx_q, clr_idx_d;

  logic [ADDR_W-3:0] widx_full;
  logic [MemAw-1:0]  widx;
  logic [1:0]        off;
  logic              oob, misalign, illegal, err, acc, wr_en, rd_en;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;

  logic              rsp_valid_q, err_q, ld_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic [31:0]       word_q;
  logic [7:0]        sel_b;
  logic [15:0]       sel_h;
  logic [31:0]       ext;

  // rst_n is folded in so ready reads 0 during reset even when the sweep is skipped
  assign req_ready = (state_q == RUN) && rst_n;
  assign acc       = req_valid && req_ready;

  assign widx_full = req_addr[ADDR_W-1:2];
  assign widx      = req_addr[MemAw+1:2];
  assign off       = req_addr[1:0];
  assign oob       = 32'(widx_full) >= DEPTH;

  data_mem_align u_align (
    .funct3    (req_funct3),
    .we        (req_we),
    .off       (off),
    .wdata     (req_wdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .misalign  (misalign),
    .illegal   (illegal)
  );

  assign err   = illegal || misalign || oob;
  assign wr_en = acc && req_we && !err;
  assign rd_en = acc && !req_we;

  // Sweep / run state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RstState;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state: walk every word once, then run
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      INIT: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == MemAw'(DEPTH - 1)) begin
          state_d   = RUN;
          clr_idx_d = '0;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = RstState;
      end
    endcase
  end

  // Memory array: sweep writes, byte-enabled stores, synchronous load read
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[clr_idx_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
    if (rd_en) begin
      word_q <= mem[widx];
    end
  end

  // Response bookkeeping; reset drops any pending response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ld_q        <= 1'b0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
    end else begin
      rsp_valid_q <= acc;
      if (acc) begin
        err_q <= err;
        ld_q  <= !req_we;
        off_q <= off;
        f3_q  <= req_funct3;
      end
    end
  end

  // Lane select and sign/zero extension of the registered word
  always_comb begin
    sel_b = word_q[8*off_q +: 8];
    sel_h = off_q[1] ? word_q[31:16] : word_q[15:0];
    case (f3_q)
      F3_B:    ext = {{24{sel_b[7]}}, sel_b};
      F3_BU:   ext = {24'd0, sel_b};
      F3_H:    ext = {{16{sel_h[15]}}, sel_h};
      F3_HU:   ext = {16'd0, sel_h};
      default: ext = word_q;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q && err_q;
  assign rsp_rdata = (rsp_valid_q && ld_q && !err_q) ? ext : 32'd0;

endmodule
